pc_branch_seq: RTL

PC_BRANCH_SEQ -- requirements
Module: pc_branch_seq

---
 rtl/pc_branch_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pc_branch_seq.sv
// Program-counter sequencer with conditional/unconditional redirects and a one-slot squash bubble.
// Define HAP_LINK_STACK_EN to enable the CALL/RET link stack; otherwise CALL acts as J and RET as NOP.
module pc_branch_seq #(
    parameter logic [7:0] RESET_VEC   = 8'h00,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] flag,
    input  logic [2:0] mode,
    input  logic [7:0] target,
    input  logic [7:0] reg_target,
    input  logic       br_valid,
    input  logic       stall,
    output logic [7:0] pc,
    output logic       taken,
    output logic       flush,
    output logic       stack_err
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_BRT  = 3'b001;
    localparam logic [2:0] OP_BRF  = 3'b010;
    localparam logic [2:0] OP_J    = 3'b011;
    localparam logic [2:0] OP_JR   = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       taken_q, taken_d;
    logic       redir;
    logic [7:0] redir_pc;
    logic       push, pop;

    // Only bit 0 of the compare word carries meaning.
    logic unused_bits;

`ifdef HAP_LINK_STACK_EN
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(STACK_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);

    logic [7:0]    mem_q [STACK_DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [PW-1:0] top_idx, sp_inc;
    logic          stk_empty, stk_full;

    assign unused_bits = ^flag[7:1];
    assign top_idx     = (sp_q == '0) ? LAST_IDX : sp_q - PW'(1);
    assign sp_inc      = (sp_q == LAST_IDX) ? '0 : sp_q + PW'(1);
    assign stk_empty   = (cnt_q == '0);
    assign stk_full    = (cnt_q == FULL_CNT);
`else
    assign unused_bits = ^flag[7:1] ^ (STACK_DEPTH != 0);
`endif

    // Redirect decode; only meaningful when RUN, unstalled and br_valid.
    always_comb begin
        redir    = 1'b0;
        redir_pc = target;
        push     = 1'b0;
        pop      = 1'b0;
        case (mode)
            OP_BRT:  redir = flag[0];
            OP_BRF:  redir = ~flag[0];
            OP_J:    redir = 1'b1;
            OP_JR: begin
                redir    = 1'b1;
                redir_pc = reg_target;
            end
            OP_CALL: begin
                redir = 1'b1;
`ifdef HAP_LINK_STACK_EN
                push  = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef HAP_LINK_STACK_EN
                redir    = 1'b1;
                pop      = 1'b1;
                redir_pc = stk_empty ? RESET_VEC : mem_q[top_idx];
`endif
            end
            OP_NOP:  redir = 1'b0;
            default: redir = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (br_valid && redir) begin
                        pc_d    = redir_pc;
                        taken_d = 1'b1;
                        state_d = FLUSH;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
                FLUSH: begin
                    pc_d    = pc_q + 8'd1;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VEC;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

`ifdef HAP_LINK_STACK_EN
    logic do_push, do_pop;

    assign do_push = push && br_valid && !stall && (state_q == RUN);
    assign do_pop  = pop  && br_valid && !stall && (state_q == RUN);

    // A push into a full circular stack lands on the oldest slot, which sp_q already points at.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (do_push) begin
            sp_d = sp_inc;
            if (stk_full) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (do_pop) begin
            if (stk_empty) begin
                err_d = 1'b1;
            end else begin
                sp_d  = top_idx;
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[sp_q] <= pc_q;
        end
    end

    assign stack_err = err_q;
`else
    logic unused_ctl;
    assign unused_ctl = push ^ pop;
    assign stack_err  = 1'b0;
`endif

    assign pc    = pc_q;
    assign taken = taken_q;
    assign flush = (state_q == FLUSH);

endmodule
